// File: rtl/instr_types_pkg.sv
// Shared instruction/PC types for the fetch-to-dispatch path.
package instr_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [13:0] pc_t;

  // One instruction queue slot: the fetched word plus its PC and predicted next PC.
  typedef struct packed {
    word_t instr;
    pc_t   PC;
    pc_t   nPC;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Decoupling FIFO between fetch_unit and dispatch. Throttles fetch with a skid margin
// and discards everything on a resolved redirect.
module instr_queue
  import instr_types_pkg::*;
#(
  parameter int IQ_DEPTH     = 8,
  parameter int SKID         = 2,
  parameter int LOG_IQ_DEPTH = $clog2(IQ_DEPTH)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    fetch_ivalid,
  input  logic [31:0]             fetch_instr,
  input  logic [13:0]             fetch_PC,
  input  logic [13:0]             fetch_nPC,
  input  logic                    flush,
  input  logic                    dispatch_ready,
  output logic                    dispatch_valid,
  output logic [31:0]             dispatch_instr,
  output logic [13:0]             dispatch_PC,
  output logic [13:0]             dispatch_nPC,
  output logic                    stall_fetch_unit,
  output logic [LOG_IQ_DEPTH:0]   iq_count,
  output logic                    iq_overflow
);

  localparam logic [LOG_IQ_DEPTH:0] FULL_COUNT  = (LOG_IQ_DEPTH+1)'(IQ_DEPTH);
  localparam logic [LOG_IQ_DEPTH:0] STALL_COUNT = (LOG_IQ_DEPTH+1)'(IQ_DEPTH - SKID);

  iq_entry_t                 entries [IQ_DEPTH];
  logic [LOG_IQ_DEPTH-1:0]   head, tail;
  logic [LOG_IQ_DEPTH-1:0]   head_next, tail_next;
  logic [LOG_IQ_DEPTH:0]     count, count_next;
  logic                      full, enq, deq, drop_full;
  iq_entry_t                 head_entry;

  assign full      = (count == FULL_COUNT);
  assign deq       = dispatch_valid & dispatch_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign enq       = fetch_ivalid & ~flush & (~full | deq);
  assign drop_full = fetch_ivalid & ~flush & full & ~deq;

  always_comb begin
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (deq) head_next = head + 1'b1;
      if (enq) tail_next = tail + 1'b1;
      if (enq && !deq)
        count_next = count + 1'b1;
      else if (deq && !enq)
        count_next = count - 1'b1;
    end
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Entries survive a flush; only the pointers forget them.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < IQ_DEPTH; i++)
        entries[i] <= '0;
    end else if (enq) begin
      entries[tail] <= '{instr: fetch_instr, PC: fetch_PC, nPC: fetch_nPC};
    end
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST)
      iq_overflow <= 1'b0;
    else if (drop_full)
      iq_overflow <= 1'b1;
  end

  assign head_entry       = entries[head];
  assign dispatch_valid   = (count != '0);
  assign dispatch_instr   = head_entry.instr;
  assign dispatch_PC      = head_entry.PC;
  assign dispatch_nPC     = head_entry.nPC;
  assign stall_fetch_unit = (count >= STALL_COUNT);
  assign iq_count         = count;

endmodule
